fsqrt_issue: RTL and testbench

FSQRT_ISSUE -- requirements
Module: fsqrt_issue

---
 rtl/fsqrt_issue.sv | 151 +++++++++++++++
 tb/tb_fsqrt_issue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_issue.sv
// Square-root issue wrapper: classifies operands, drives an external
// one-cycle sqrt datapath and buffers results in order with a tag.
module fsqrt_issue #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      sq_a,
  input  logic [31:0]      sq_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_invalid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    C_NORM,
    C_ZERO,
    C_PINF,
    C_NAN,
    C_NEG
  } cls_e;

  cls_e             in_cls;
  logic             s1_v_q;
  logic [31:0]      s1_data_q;
  logic [TAG_W-1:0] s1_tag_q;
  cls_e             s1_cls_q;
  logic             s2_v_q;
  logic             s2_sign_q;
  logic [TAG_W-1:0] s2_tag_q;
  cls_e             s2_cls_q;

  logic [31:0]      mem_d_q [DEPTH];
  logic [TAG_W-1:0] mem_t_q [DEPTH];
  logic             mem_i_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW:0]      occ;

  logic             accept;
  logic             push;
  logic             pop;
  logic [31:0]      res_d;
  logic             res_inv;

  always_comb begin
    in_cls = C_NORM;
    if (in_data[30:23] == 8'h00) begin
      in_cls = C_ZERO;
    end else if (in_data[30:23] == 8'hFF &&
                 in_data[22:0] == 23'd0 &&
                 !in_data[31]) begin
      in_cls = C_PINF;
    end else if (in_data[30:23] == 8'hFF &&
                 in_data[22:0] != 23'd0) begin
      in_cls = C_NAN;
    end else if (in_data[31]) begin
      in_cls = C_NEG;
    end
  end

  // Reserve a FIFO slot for every operand still in S1/S2.
  assign occ = {1'b0, cnt_q}
             + (CW+1)'(s1_v_q)
             + (CW+1)'(s2_v_q);
  assign in_ready = (occ < (CW+1)'(DEPTH));
  assign accept = in_valid && in_ready;

  assign sq_a = s1_v_q ? s1_data_q : 32'd0;

  always_comb begin
    res_d   = sq_b;
    res_inv = 1'b0;
    unique case (s2_cls_q)
      C_ZERO: res_d = {s2_sign_q, 31'd0};
      C_PINF: res_d = 32'h7F80_0000;
      C_NAN:  res_d = 32'h7FC0_0000;
      C_NEG: begin
        res_d   = 32'h7FC0_0000;
        res_inv = 1'b1;
      end
      default: res_d = sq_b;
    endcase
  end

  assign out_valid = (cnt_q != '0);
  assign push = s2_v_q;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= 32'd0;
      s1_tag_q  <= '0;
      s1_cls_q  <= C_NORM;
      s2_v_q    <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_tag_q  <= '0;
      s2_cls_q  <= C_NORM;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= accept;
      if (accept) begin
        s1_data_q <= in_data;
        s1_tag_q  <= in_tag;
        s1_cls_q  <= in_cls;
      end
      s2_v_q    <= s1_v_q;
      s2_sign_q <= s1_data_q[31];
      s2_tag_q  <= s1_tag_q;
      s2_cls_q  <= s1_cls_q;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_d_q[wr_q] <= res_d;
      mem_t_q[wr_q] <= s2_tag_q;
      mem_i_q[wr_q] <= res_inv;
    end
  end

  assign out_data    = out_valid ? mem_d_q[rd_q] : 32'd0;
  assign out_tag     = out_valid ? mem_t_q[rd_q] : '0;
  assign out_invalid = out_valid ? mem_i_q[rd_q] : 1'b0;

endmodule

// File: tb/tb_fsqrt_issue.sv
// Directed bench for fsqrt_issue with a queue scoreboard and a
// behavioural one-cycle sqrt datapath.
module tb_fsqrt_issue;

  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = 32'd0;
  logic [TW-1:0] in_tag = '0;
  logic [31:0]   sq_a;
  logic [31:0]   sq_b = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [TW-1:0] out_tag;
  logic          out_invalid;

  fsqrt_issue #(.TAG_W(TW), .DEPTH(4)) dut (
    .clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_tag(in_tag),
    .sq_a(sq_a),
    .sq_b(sq_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag),
    .out_invalid(out_invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   d;
    logic [TW-1:0] t;
    logic          inv;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [31:0] model(input logic [31:0] a);
    case (a)
      32'h3F80_0000: model = 32'h3F80_0000;
      32'h4080_0000: model = 32'h4000_0000;
      32'h4110_0000: model = 32'h4040_0000;
      32'h4180_0000: model = 32'h4080_0000;
      32'h42C8_0000: model = 32'h4120_0000;
      32'h4000_0000: model = 32'h3FB5_04F3;
      default:       model = {9'h0AA, a[22:0]};
    endcase
  endfunction

  always @(posedge clk) sq_b <= model(sq_a);

  function automatic exp_t ref_of(input logic [31:0] d,
                                  input logic [TW-1:0] t);
    exp_t e;
    logic [7:0] ex;
    ex = d[30:23];
    e.t = t;
    e.inv = 1'b0;
    if (ex == 8'd0)                          e.d = {d[31], 31'd0};
    else if (ex == 8'hFF && d[22:0] != 0)    e.d = 32'h7FC0_0000;
    else if (ex == 8'hFF && !d[31])          e.d = 32'h7F80_0000;
    else if (d[31]) begin
      e.d = 32'h7FC0_0000;
      e.inv = 1'b1;
    end else                                 e.d = model(d);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_tag", 64'(out_tag), 64'(e.t));
          chk("out_invalid", 64'(out_invalid), 64'(e.inv));
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_of(in_data, in_tag));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [TW-1:0] t);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_tag = t;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [31:0] spc [5];
  logic [31:0] nrm [6];

  initial begin
    logic [31:0] hd;
    logic [TW-1:0] ht;
    int idx;
    logic a;

    spc[0] = 32'hC080_0000; spc[1] = 32'h8000_0000;
    spc[2] = 32'h7F80_0000; spc[3] = 32'h7FA0_0000;
    spc[4] = 32'h0000_0001;
    nrm[0] = 32'h3F80_0000; nrm[1] = 32'h4080_0000;
    nrm[2] = 32'h4110_0000; nrm[3] = 32'h4180_0000;
    nrm[4] = 32'h42C8_0000; nrm[5] = 32'h4000_0000;

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sq_a", 64'(sq_a), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_inv", 64'(out_invalid), 64'd0);
    tick();
    rstn = 1'b1;
    tick();

    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h4080_0000;
    in_tag = 5'd3;
    tick();
    in_valid = 1'b0;
    chk("lat_sq_a", 64'(sq_a), 64'h4080_0000);
    chk("lat_k0", 64'(out_valid), 64'd0);
    tick();
    chk("lat_k1", 64'(out_valid), 64'd0);
    tick();
    chk("lat_k2", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(out_data), 64'h4000_0000);
    chk("lat_tag", 64'(out_tag), 64'd3);
    drain();

    for (int i = 0; i < 5; i++) send(spc[i], TW'(i + 8));
    drain();

    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_data = nrm[idx];
      in_tag = TW'(idx + 16);
      a = in_ready;
      tick();
      if (a) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd4);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    hd = out_data;
    ht = out_tag;
    tick();
    tick();
    chk("bp_stable_data", 64'(out_data), 64'(hd));
    chk("bp_stable_tag", 64'(out_tag), 64'(ht));
    chk("bp_head", 64'(hd), 64'(model(nrm[0])));
    out_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      in_data = nrm[idx];
      in_tag = TW'(idx + 16);
      a = in_ready;
      tick();
      if (a) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd6);
    drain();

    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = nrm[i % 6];
      in_tag = TW'(i);
      if (i >= 3) begin
        chk("stream_in_ready", 64'(in_ready), 64'd1);
        chk("stream_out_valid", 64'(out_valid), 64'd1);
      end
      tick();
    end
    in_valid = 1'b0;
    drain();

    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = nrm[i];
      in_tag = TW'(i + 24);
      chk("pre_rst_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_sq_a", 64'(sq_a), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    sb.delete();
    tick();
    tick();
    rstn = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h4110_0000;
    in_tag = 5'd21;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("post_rst_sq_a", 64'(sq_a), 64'h4110_0000);
    chk("no_stale_0", 64'(out_valid), 64'd0);
    tick();
    chk("no_stale_1", 64'(out_valid), 64'd0);
    tick();
    chk("post_rst_result", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    drain();
    tick();
    tick();
    chk("final_idle", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
